apb_req_bridge: RTL and testbench
=================================

Name: apb_req_bridge

Overview:
- Converts a simple valid/ready request/response port into APB3 master transfers.
- Sits directly upstream of the APB slave port on top_mod and drives that module's apb_if.
- Handles one outstanding transfer at a time.
- Adds a bus-hang timeout so an unresponsive slave cannot stall the requester.

Parameters:
- ADDR_W, 32: request and APB address width.
- DATA_W, 32: request, response and APB data width (8, 16 or 32).
- TIMEOUT, 256: maximum ACCESS-phase cycles before forced completion; 0 disables the timeout.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_err  out  1  pslverr was returned, or a timeout occurred.
- rsp_timeout  out  1  the transfer ended by timeout.
- apb  apb_if.master  -  Uses paddr, psel, penable, pwrite, pwdata, prdata, pready and pslverr.

Behaviour:
- Reset is synchronous: rst sampled low at a clk edge forces the following state.
  - State = IDLE.
  - psel, penable, pwrite = 0; paddr = 0; pwdata = 0.
  - rsp_valid, rsp_err, rsp_timeout = 0; rsp_rdata = 0.
  - Timeout counter = 0.
  - req_ready is forced to 0 while rst is low.
- States: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch write, addr and wdata; go to SETUP.
  - paddr = req_addr with the low log2(DATA_W/8) bits cleared.
- SETUP (exactly 1 cycle): psel = 1, penable = 0, paddr/pwrite/pwdata driven from the latched values.
- ACCESS:
  - psel = 1, penable = 1; all other APB outputs held stable.
  - The counter increments each ACCESS cycle.
  - Normal completion: on the edge where pready = 1, capture prdata (reads only; writes store 0) and pslverr into rsp_rdata / rsp_err; go to RESP.
  - Timeout: if TIMEOUT != 0 and the counter reaches TIMEOUT-1 with pready = 0, go to RESP with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - pready = 1 in the final timeout cycle counts as normal completion; rsp_timeout stays 0.
- RESP:
  - psel = 0, penable = 0.
  - rsp_valid = 1; rsp_* held stable until rsp_valid & rsp_ready.
  - On that handshake, go to IDLE and clear rsp_err, rsp_timeout and the counter.
- Latency:
  - Request accepted at edge N gives SETUP in cycle N+1 and ACCESS in cycle N+2.
  - With zero wait states, rsp_valid is high in cycle N+3.
  - Each wait state adds 1 cycle.
- Throughput:
  - The next request can be accepted 1 cycle after the response handshake (IDLE cycle).
  - Minimum 4 cycles per transfer.
- pready and pslverr are ignored outside ACCESS.
- paddr, pwrite and pwdata hold their last values in IDLE and RESP; there is no spurious toggling.
- rst low during SETUP, ACCESS or RESP:
  - The transfer is abandoned and psel drops at that edge.
  - No response is produced.
  - The requester must reissue.
- A held rsp_valid with rsp_ready = 0 blocks indefinitely; there is no timeout on the response side.

Decomposition:
- apb_bridge_pkg contains:
  - enum bridge_state_e {IDLE, SETUP, ACCESS, RESP};
  - default width localparams;
  - function addr_align(addr, DATA_W).
- One sub-module, apb_timeout_ctr:
  - Load-clear/enable counter, width $clog2(TIMEOUT+1).
  - Outputs expired = (count == TIMEOUT-1) & (TIMEOUT != 0).
  - Same clk/rst semantics as the parent.

Test Plan:
1. Write with zero wait states:
   - Stimulus: req write, addr=0x0000_1004, wdata=0xDEAD_BEEF; slave pready=1, pslverr=0.
   - Required: SETUP cycle N+1, ACCESS cycle N+2 with paddr=0x1004, pwrite=1, pwdata=0xDEADBEEF; rsp_valid in N+3 with err=0, rdata=0.
2. Read with 3 wait states:
   - Stimulus: req read, addr=0x23; slave pready low for 3 ACCESS cycles then high, prdata=0x1234_5678.
   - Required: paddr=0x20; penable high for 4 cycles; rsp_rdata=0x12345678, err=0; rsp_valid in N+6.
3. Slave error:
   - Stimulus: read; pready=1 with pslverr=1.
   - Required: rsp_err=1, rsp_timeout=0, rsp_rdata=prdata.
4. Timeout:
   - Stimulus: TIMEOUT=4, pready held 0.
   - Required: exactly 4 ACCESS cycles; rsp_err=1, rsp_timeout=1, rdata=0; psel=0 in RESP.
   - Repeat with pready=1 on ACCESS cycle 4: required normal completion, rsp_timeout=0.
5. Response backpressure and back-to-back:
   - Stimulus: rsp_ready low for 5 cycles, then high; req_valid held high with a second request.
   - Required: rsp fields stable throughout; req_ready=0 until the IDLE cycle after the handshake; second transfer begins correctly.
6. Reset mid-ACCESS:
   - Stimulus: assert rst low for 1 cycle during ACCESS.
   - Required: psel=penable=0 and state IDLE after the edge; no rsp_valid; next request completes normally.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// Shared types and helpers for the valid/ready to APB3 request bridge.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } bridge_state_e;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 256;
  localparam int MAX_ADDR_W  = 64;

  // Clears the byte-offset bits below the bus word size.
  function automatic logic [MAX_ADDR_W-1:0] addr_align(input logic [MAX_ADDR_W-1:0] addr,
                                                        input int data_w);
    int lsb;
    lsb = $clog2(data_w / 8);
    return addr & ({MAX_ADDR_W{1'b1}} << lsb);
  endfunction

endpackage

// File: rtl/apb_if.sv
// APB3 signal bundle with master and slave views.
interface apb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase cycle counter; expired flags the last allowed cycle before forced completion.
module apb_timeout_ctr #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // A zero TIMEOUT leaves the counter running but never lets it fire.
  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = (count_reg == LAST);
    end
  endgenerate

endmodule

// File: rtl/apb_req_bridge.sv
// Single-outstanding valid/ready request port to APB3 master, with ACCESS-phase hang timeout.
module apb_req_bridge
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  apb_if.master             apb
);

  bridge_state_e state_reg, state_next;

  logic [ADDR_W-1:0] paddr_reg;
  logic              pwrite_reg;
  logic [DATA_W-1:0] pwdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;
  logic              tmo_reg;

  logic accept;
  logic complete;
  logic time_out;
  logic handshake;
  logic expired;
  logic psel;
  logic penable;
  logic in_access;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    complete   = 1'b0;
    time_out   = 1'b0;
    handshake  = 1'b0;
    psel       = 1'b0;
    penable    = 1'b0;
    rsp_valid  = 1'b0;
    req_ready  = 1'b0;
    in_access  = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = rst;
        if (req_valid && rst) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        psel       = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        psel      = 1'b1;
        penable   = 1'b1;
        in_access = 1'b1;
        // pready wins over the timeout in the final allowed cycle.
        if (apb.pready) begin
          complete   = 1'b1;
          state_next = RESP;
        end else if (expired) begin
          time_out   = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          handshake  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      paddr_reg  <= '0;
      pwrite_reg <= 1'b0;
      pwdata_reg <= '0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
      tmo_reg    <= 1'b0;
    end else begin
      if (accept) begin
        paddr_reg  <= ADDR_W'(addr_align(MAX_ADDR_W'(req_addr), DATA_W));
        pwrite_reg <= req_write;
        pwdata_reg <= req_wdata;
      end
      if (complete) begin
        rdata_reg <= pwrite_reg ? '0 : apb.prdata;
        err_reg   <= apb.pslverr;
        tmo_reg   <= 1'b0;
      end
      if (time_out) begin
        rdata_reg <= '0;
        err_reg   <= 1'b1;
        tmo_reg   <= 1'b1;
      end
      if (handshake) begin
        err_reg <= 1'b0;
        tmo_reg <= 1'b0;
      end
    end
  end

  apb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .clk    (clk),
    .rst    (rst),
    .clear  (handshake),
    .enable (in_access),
    .expired(expired)
  );

  assign apb.paddr   = paddr_reg;
  assign apb.psel    = psel;
  assign apb.penable = penable;
  assign apb.pwrite  = pwrite_reg;
  assign apb.pwdata  = pwdata_reg;

  assign rsp_rdata   = rdata_reg;
  assign rsp_err     = err_reg;
  assign rsp_timeout = tmo_reg;

endmodule

// File: tb/tb_apb_req_bridge.sv
// Scoreboard bench for apb_req_bridge: stimulus pushes expected responses, a monitor checks them.
module tb_apb_req_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  always #5 clk = ~clk;

  apb_if #(.ADDR_W(32), .DATA_W(32)) apb_bus ();

  apb_req_bridge #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .apb        (apb_bus)
  );

  // Slave model: pready rises after ws wait states within ACCESS.
  int          ws = 0;
  int          acc_i = 0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err = 1'b0;

  always @(posedge clk) acc_i <= (apb_bus.psel && apb_bus.penable) ? acc_i + 1 : 0;
  assign apb_bus.pready  = apb_bus.psel && apb_bus.penable && (acc_i == ws);
  assign apb_bus.prdata  = slv_rdata;
  assign apb_bus.pslverr = slv_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    int          acc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   accept_q[$];
  int   ncmp = 0;
  int   nfail = 0;
  int   cyc = 0;
  int   last_acc = -1;
  int   last_hs = -1;
  int   txn = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    ncmp++;
    if (act !== want) begin
      nfail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic void expect_rsp(input logic [31:0] rdata, input logic err, input logic tmo,
                                     input logic [31:0] paddr, input logic pwrite,
                                     input logic [31:0] pwdata, input int acc, input int lat);
    exp_t e;
    e.rdata = rdata; e.err = err; e.tmo = tmo; e.paddr = paddr;
    e.pwrite = pwrite; e.pwdata = pwdata; e.acc = acc; e.lat = lat;
    exp_q.push_back(e);
  endfunction

  // Monitor: tracks APB phases and pops the scoreboard on each response handshake.
  logic [31:0] s_paddr, s_pwdata, h_rdata;
  logic        s_pwrite, h_err, h_tmo;
  int          acc_cnt = 0;
  int          first_rsp = 0;
  bit          in_rsp = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    int   a;
    cyc++;
    if (!rst) begin
      accept_q.delete();
      acc_cnt = 0;
      in_rsp  = 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        accept_q.push_back(cyc);
        last_acc = cyc;
      end
      if (apb_bus.psel && !apb_bus.penable) begin
        s_paddr  = apb_bus.paddr;
        s_pwrite = apb_bus.pwrite;
        s_pwdata = apb_bus.pwdata;
        acc_cnt  = 0;
      end
      if (apb_bus.psel && apb_bus.penable) begin
        acc_cnt++;
        chk("paddr_stable", apb_bus.paddr, s_paddr);
        chk("pwrite_stable", apb_bus.pwrite, s_pwrite);
        chk("pwdata_stable", apb_bus.pwdata, s_pwdata);
      end
      if (rsp_valid) begin
        chk("req_ready_in_resp", req_ready, 0);
        if (!in_rsp) begin
          in_rsp    = 1'b1;
          first_rsp = cyc;
          h_rdata   = rsp_rdata;
          h_err     = rsp_err;
          h_tmo     = rsp_timeout;
          chk("psel_in_resp", apb_bus.psel, 0);
          chk("penable_in_resp", apb_bus.penable, 0);
          chk("paddr_hold_resp", apb_bus.paddr, s_paddr);
        end else begin
          chk("rdata_stable", rsp_rdata, h_rdata);
          chk("err_stable", rsp_err, h_err);
          chk("tmo_stable", rsp_timeout, h_tmo);
        end
        if (rsp_ready) begin
          in_rsp  = 1'b0;
          last_hs = cyc;
          if (exp_q.size() == 0 || accept_q.size() == 0) begin
            ncmp++;
            nfail++;
            $display("FAIL unexpected_rsp: got rdata %h with no request pending, want none", rsp_rdata);
          end else begin
            e = exp_q.pop_front();
            a = accept_q.pop_front();
            txn++;
            $display("txn %0d: addr=%h write=%b rdata=%h err=%b tmo=%b access=%0d latency=%0d",
                     txn, s_paddr, s_pwrite, rsp_rdata, rsp_err, rsp_timeout, acc_cnt, first_rsp - a);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_timeout", rsp_timeout, e.tmo);
            chk("paddr", s_paddr, e.paddr);
            chk("pwrite", s_pwrite, e.pwrite);
            chk("pwdata", s_pwdata, e.pwdata);
            chk("access_cycles", acc_cnt, e.acc);
            chk("latency", first_rsp - a, e.lat);
          end
        end
      end
    end
  end

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    bit got = 1'b0;
    @(posedge clk); #1;
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = req_ready;
    end
    if (!got) begin
      ncmp++; nfail++;
      $display("FAIL accept_timeout: got req_ready 0 for 50 cycles, want 1");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0);
    end
    if (!done) begin
      ncmp++; nfail++;
      $display("FAIL drain_timeout: got %0d responses pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_psel", apb_bus.psel, 0);
    chk("rst_penable", apb_bus.penable, 0);
    chk("rst_pwrite", apb_bus.pwrite, 0);
    chk("rst_paddr", apb_bus.paddr, 0);
    chk("rst_pwdata", apb_bus.pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_req_ready", req_ready, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);

    // Zero-wait write
    ws = 0; slv_rdata = 32'hAAAA_5555; slv_err = 1'b0;
    expect_rsp(32'h0, 0, 0, 32'h0000_1004, 1, 32'hDEAD_BEEF, 1, 3);
    send(1, 32'h0000_1004, 32'hDEAD_BEEF);
    wait_done();

    // Read with 3 wait states, unaligned address
    ws = 3; slv_rdata = 32'h1234_5678;
    expect_rsp(32'h1234_5678, 0, 0, 32'h20, 0, 32'h0, 4, 6);
    send(0, 32'h23, 32'h0);
    wait_done();

    // Slave error on a read
    ws = 1; slv_rdata = 32'hCAFE_F00D; slv_err = 1'b1;
    expect_rsp(32'hCAFE_F00D, 1, 0, 32'h40, 0, 32'h5A5A_5A5A, 2, 4);
    send(0, 32'h42, 32'h5A5A_5A5A);
    wait_done();

    // Timeout: slave never ready
    ws = 99; slv_rdata = 32'h5555_5555; slv_err = 1'b0;
    expect_rsp(32'h0, 1, 1, 32'h100, 0, 32'h0, 4, 6);
    send(0, 32'h100, 32'h0);
    wait_done();

    // pready in the final allowed cycle completes normally
    ws = 3;
    expect_rsp(32'h0, 0, 0, 32'h104, 1, 32'h0BAD_F00D, 4, 6);
    send(1, 32'h107, 32'h0BAD_F00D);
    wait_done();

    // Response backpressure with a queued second request
    ws = 0; slv_rdata = 32'h1111_2222; slv_err = 1'b0;
    expect_rsp(32'h1111_2222, 0, 0, 32'h200, 0, 32'h0, 1, 3);
    expect_rsp(32'h0, 0, 0, 32'h204, 1, 32'h600D_CAFE, 1, 3);
    @(posedge clk); #1 rsp_ready = 1'b0;
    fork
      begin
        bit v = 1'b0;
        for (int i = 0; i < 50 && !v; i++) begin
          @(negedge clk);
          v = rsp_valid;
        end
        repeat (5) @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join_none
    send(0, 32'h200, 32'h0);
    send(1, 32'h204, 32'h600D_CAFE);
    chk("b2b_accept_gap", last_acc - last_hs, 1);
    wait_done();

    // Reset during ACCESS abandons the transfer
    ws = 99;
    send(0, 32'h300, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = apb_bus.penable;
    end
    chk("reached_access", seen, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("req_ready_in_rst", req_ready, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_psel", apb_bus.psel, 0);
    chk("midrst_penable", apb_bus.penable, 0);
    chk("midrst_paddr", apb_bus.paddr, 0);
    chk("midrst_idle", req_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_no_rsp", rsp_valid, 0);
    end

    // Normal transfer after the abandoned one
    ws = 2; slv_rdata = 32'h89AB_CDEF;
    expect_rsp(32'h89AB_CDEF, 0, 0, 32'h300, 0, 32'h0, 3, 5);
    send(0, 32'h300, 32'h0);
    wait_done();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
